// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU port, port-1 (debug/display) port and DMEM bus signals
// shared between the data-memory arbiter and its neighbours.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              cpu_r;
  logic              cpu_w;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;

  logic              mem_ena;
  logic              mem_r;
  logic              mem_w;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              grant_p1;

  modport slave (
    input  cpu_r, cpu_w, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_ack, p1_rdata,
    output mem_ena, mem_r, mem_w, mem_addr, mem_wdata,
    input  mem_rdata,
    output grant_p1
  );

  modport master (
    output cpu_r, cpu_w, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_ack, p1_rdata,
    input  mem_ena, mem_r, mem_w, mem_addr, mem_wdata,
    output mem_rdata,
    input  grant_p1
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port DMEM arbiter: CPU has fixed priority, port 1 waits up to
// MAX_WAIT cycles before the CPU is stalled for one forced port-1 access.
module dmem_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FORCE, S_DONE} state_e;

  state_e            state_q;
  logic [7:0]        cnt_q;
  logic              cpu_stall_q;
  logic              p1_ack_q;
  logic [DATA_W-1:0] p1_rdata_q;

  logic              cpu_busy;
  logic              grant;
  logic              mem_r;
  logic              mem_w;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  assign cpu_busy = bus.cpu_r | bus.cpu_w;

  // Grant is decided in the same cycle as the request so an idle CPU costs
  // port 1 no latency; it is held off while reset is asserted.
  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    grant = 1'b0;
    if (rst) begin
      unique case (state_q)
        S_IDLE, S_WAIT: grant = bus.p1_req & ~cpu_busy;
        S_FORCE:        grant = 1'b1;
        default:        grant = 1'b0;
      endcase
    end
  end

  always_comb begin
    mem_addr  = bus.cpu_addr;
    mem_wdata = bus.cpu_wdata;
    mem_r     = bus.cpu_r & ~cpu_stall_q;
    mem_w     = bus.cpu_w & ~cpu_stall_q;
    if (grant) begin
      mem_addr  = bus.p1_addr;
      mem_wdata = bus.p1_wdata;
      mem_r     = ~bus.p1_we;
      mem_w     = bus.p1_we;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      cpu_stall_q <= 1'b0;
      p1_ack_q    <= 1'b0;
      p1_rdata_q  <= '0;
    end else begin
      cpu_stall_q <= 1'b0;
      p1_ack_q    <= 1'b0;
      if (grant && !bus.p1_we) p1_rdata_q <= bus.mem_rdata;

      unique case (state_q)
        S_IDLE: begin
          if (bus.p1_req && !cpu_busy) begin
            state_q  <= S_DONE;
            p1_ack_q <= 1'b1;
          end else if (bus.p1_req) begin
            state_q <= S_WAIT;
            cnt_q   <= 8'd1;
          end
        end
        S_WAIT: begin
          if (!bus.p1_req) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
          end else if (!cpu_busy) begin
            state_q  <= S_DONE;
            p1_ack_q <= 1'b1;
            cnt_q    <= 8'd0;
          end else if (cnt_q == 8'(MAX_WAIT - 1)) begin
            state_q     <= S_FORCE;
            cpu_stall_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_FORCE: begin
          state_q  <= S_DONE;
          p1_ack_q <= 1'b1;
          cnt_q    <= 8'd0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.cpu_stall = cpu_stall_q;
  assign bus.p1_ack    = p1_ack_q;
  assign bus.p1_rdata  = p1_rdata_q;
  assign bus.grant_p1  = grant;
  assign bus.mem_r     = mem_r;
  assign bus.mem_w     = mem_w;
  assign bus.mem_ena   = mem_r | mem_w;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

endmodule
